// File: rtl/rnn_pkg.sv
// Shared definitions for the rnn_param Elman RNN cell engine.
//   - msel region codes for the shared parameter/output memory port
//   - FSM state encoding
//   - hardtanh limits (+1.0 / -1.0) for a given fraction width
//   - address-width sanity check used at elaboration
package rnn_pkg;

  localparam logic [2:0] MSEL_WIH  = 3'b000;
  localparam logic [2:0] MSEL_BIH  = 3'b001;
  localparam logic [2:0] MSEL_WHH  = 3'b010;
  localparam logic [2:0] MSEL_BHH  = 3'b011;
  localparam logic [2:0] MSEL_LEN  = 3'b100;
  localparam logic [2:0] MSEL_HOUT = 3'b101;

  typedef enum logic [2:0] {
    StIdle, StLen, StBias, StFetchx, StHh, StIh, StSum, StWr
  } rnn_state_e;

  // +1.0 and -1.0 in a fixed-point format with frac fractional bits.
  function automatic longint ht_pos(int unsigned frac);
    return longint'(1) <<< frac;
  endfunction

  function automatic longint ht_neg(int unsigned frac);
    return -(longint'(1) <<< frac);
  endfunction

  // maddr must cover W_hh (H*H), W_ih (H*N) and the {t, j} output address.
  function automatic bit aw_ok(int unsigned h, int unsigned n, int unsigned tw,
                               int unsigned aw);
    return (aw >= $clog2(h * h)) && (aw >= $clog2(h * n)) && (aw >= tw + $clog2(h));
  endfunction

endpackage

// File: rtl/rnn_mac.sv
// Serial signed multiply-accumulate for the recurrent (W_hh * h_prev) term.
// One DW x DW product per enabled cycle into a wide accumulator that cannot
// overflow for H terms; res_o is the accumulator scaled back to FRAC format.
// Build option RNN_ROUND_EN: add 2^(FRAC-1) before the >>FRAC (round half up);
// otherwise the shift floors.
// Ports:
//   clk_i, rst_i  clock, asynchronous active-high reset
//   clr_i         zero the accumulator (wins over en_i)
//   en_i          accumulate a_i * b_i
//   a_i, b_i      signed operands
//   res_o         (acc [+ half]) >>> FRAC, sign-extended to AccW bits
module rnn_mac #(
  parameter int unsigned DW   = 20,
  parameter int unsigned FRAC = 16,
  parameter int unsigned AccW = 46
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clr_i,
  input  logic                   en_i,
  input  logic signed [DW-1:0]   a_i,
  input  logic signed [DW-1:0]   b_i,
  output logic signed [AccW-1:0] res_o
);

`ifdef RNN_ROUND_EN
  localparam logic signed [AccW-1:0] Half = (AccW'(1) << FRAC) >> 1;
`else
  localparam logic signed [AccW-1:0] Half = '0;
`endif

  logic signed [2*DW-1:0] prod;
  logic signed [AccW-1:0] acc_q, acc_d, biased;

  assign prod = (2*DW)'(a_i) * (2*DW)'(b_i);

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + {{(AccW-2*DW){prod[2*DW-1]}}, prod};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign biased = acc_q + Half;
  assign res_o  = biased >>> FRAC;

endmodule

// File: rtl/rnn_param.sv
// rnn_param: parametrised Elman RNN cell engine.
// h_t = hardtanh(W_ih*x_t + B_ih + W_hh*h_(t-1) + B_hh) over L+1 timesteps.
// Build option RNN_ROUND_EN selects rounding in the W_hh term (see rnn_mac).
// Ports:
//   clk, reset  clock, asynchronous active-high reset
//   ready       start request, sampled in IDLE
//   busy        high from start accept until the last write
//   i_en        one-cycle request for the next input vector
//   idata       input vector, sampled the cycle after i_en
//   mce/msel/maddr  memory access enable, region, word address
//   mdata_r     read data, valid the cycle after the address
//   mdata_w     h_t write data (msel = 101)
module rnn_param
  import rnn_pkg::*;
#(
  parameter int unsigned HIDDEN  = 64,
  parameter int unsigned IN_BITS = 32,
  parameter int unsigned DW      = 20,
  parameter int unsigned FRAC    = 16,
  parameter int unsigned TW      = 11,
  parameter int unsigned AW      = 17
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ready,
  output logic               busy,
  output logic               i_en,
  input  logic [IN_BITS-1:0] idata,
  output logic               mce,
  output logic [2:0]         msel,
  output logic [AW-1:0]      maddr,
  input  logic [DW-1:0]      mdata_r,
  output logic [DW-1:0]      mdata_w
);

  localparam int unsigned LH   = $clog2(HIDDEN);
  localparam int unsigned LN   = $clog2(IN_BITS);
  localparam int unsigned AccW = 2 * DW + LH;
  localparam int unsigned SW   = AccW + LN + 2;
  localparam int unsigned CW   = $clog2(2 * HIDDEN + IN_BITS + 2);
  localparam logic signed [SW-1:0] HtPos = SW'(ht_pos(FRAC));
  localparam logic signed [SW-1:0] HtNeg = SW'(ht_neg(FRAC));

  if (!aw_ok(HIDDEN, IN_BITS, TW, AW)) begin : g_aw_check
    $error("rnn_param: AW too small for HIDDEN/IN_BITS/TW");
  end

  rnn_state_e          state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [LH-1:0]       j_q, j_d;
  logic [TW-1:0]       t_q, t_d, len_q, len_d;
  logic [IN_BITS-1:0]  x_q, x_d;
  logic [DW-1:0]       bih_q, bih_d;
  logic signed [DW:0]   bias_q [HIDDEN], bias_d [HIDDEN];
  logic signed [DW-1:0] hprev_q [HIDDEN], hprev_d [HIDDEN];
  logic signed [DW-1:0] hnew_q [HIDDEN], hnew_d [HIDDEN];
  logic signed [SW-1:0] ih_q, ih_d;

  logic                 mac_clr, mac_en;
  logic [LH-1:0]        hidx, bidx;
  logic [LN-1:0]        xidx;
  logic signed [AccW-1:0] mac_res;
  logic signed [SW-1:0] sum;
  logic signed [DW:0]   bsel;
  logic [DW+TW-1:0]     lraw;

  rnn_mac #(.DW(DW), .FRAC(FRAC), .AccW(AccW)) u_mac (
    .clk_i (clk),
    .rst_i (reset),
    .clr_i (mac_clr),
    .en_i  (mac_en),
    .a_i   ($signed(mdata_r)),
    .b_i   (hprev_q[hidx]),
    .res_o (mac_res)
  );

  assign busy = (state_q != StIdle);
  assign hidx = LH'(cnt_q - CW'(1));
  assign xidx = LN'(cnt_q - CW'(1));
  assign bidx = LH'((cnt_q >> 1) - CW'(1));
  assign lraw = (DW+TW)'(mdata_r);
  assign bsel = bias_q[j_q];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    j_d     = j_q;
    t_d     = t_q;
    len_d   = len_q;
    x_d     = x_q;
    bih_d   = bih_q;
    bias_d  = bias_q;
    hprev_d = hprev_q;
    hnew_d  = hnew_q;
    ih_d    = ih_q;
    mce     = 1'b0;
    msel    = '0;
    maddr   = '0;
    mdata_w = '0;
    i_en    = 1'b0;
    mac_clr = 1'b0;
    mac_en  = 1'b0;
    sum     = '0;
    unique case (state_q)
      StIdle: begin
        if (ready) begin
          state_d = StLen;
          cnt_d   = '0;
          j_d     = '0;
          t_d     = '0;
          for (int k = 0; k < HIDDEN; k++) hprev_d[k] = '0;
        end
      end
      StLen: begin
        mce     = 1'b1;
        msel    = MSEL_LEN;
        state_d = StBias;
        cnt_d   = '0;
      end
      StBias: begin
        // Even count reads B_ih[j], odd reads B_hh[j]; data lags by one cycle,
        // so cycle 0 sees the length word and 2H+1 is the drain cycle.
        if (cnt_q < CW'(2 * HIDDEN)) begin
          mce   = 1'b1;
          msel  = cnt_q[0] ? MSEL_BHH : MSEL_BIH;
          maddr = AW'(cnt_q >> 1);
        end
        if (cnt_q == '0) begin
          len_d = (lraw >= (DW+TW)'({TW{1'b1}})) ? '1 : lraw[TW-1:0];
        end else if (cnt_q[0]) begin
          bih_d = mdata_r;
        end else begin
          bias_d[bidx] = {bih_q[DW-1], bih_q} + {mdata_r[DW-1], mdata_r};
        end
        if (cnt_q == CW'(2 * HIDDEN + 1)) begin
          state_d = StFetchx;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StFetchx: begin
        if (cnt_q == '0) begin
          i_en  = 1'b1;
          cnt_d = CW'(1);
        end else begin
          x_d     = idata;
          state_d = StHh;
          cnt_d   = '0;
        end
      end
      StHh: begin
        if (cnt_q < CW'(HIDDEN)) begin
          mce   = 1'b1;
          msel  = MSEL_WHH;
          maddr = AW'({j_q, cnt_q[LH-1:0]});
        end
        if (cnt_q == '0) begin
          mac_clr = 1'b1;
          ih_d    = '0;
        end else begin
          mac_en = 1'b1;
        end
        if (cnt_q == CW'(HIDDEN)) begin
          state_d = StIh;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StIh: begin
        if (cnt_q < CW'(IN_BITS)) begin
          mce   = 1'b1;
          msel  = MSEL_WIH;
          maddr = AW'({j_q, cnt_q[LN-1:0]});
        end
        if ((cnt_q != '0) && x_q[xidx]) begin
          ih_d = ih_q + {{(SW-DW){mdata_r[DW-1]}}, mdata_r};
        end
        if (cnt_q == CW'(IN_BITS)) begin
          state_d = StSum;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StSum: begin
        sum = {{(SW-AccW){mac_res[AccW-1]}}, mac_res} + ih_q
            + {{(SW-DW-1){bsel[DW]}}, bsel};
        if (sum >= HtPos) begin
          hnew_d[j_q] = HtPos[DW-1:0];
        end else if (sum < HtNeg) begin
          hnew_d[j_q] = HtNeg[DW-1:0];
        end else begin
          hnew_d[j_q] = sum[DW-1:0];
        end
        state_d = StWr;
      end
      StWr: begin
        mce     = 1'b1;
        msel    = MSEL_HOUT;
        maddr   = AW'({t_q, j_q});
        mdata_w = hnew_q[j_q];
        cnt_d   = '0;
        if (j_q == LH'(HIDDEN - 1)) begin
          j_d = '0;
          if (t_q == len_q) begin
            state_d = StIdle;
          end else begin
            // h_prev only advances once the whole timestep is written.
            t_d     = t_q + TW'(1);
            hprev_d = hnew_q;
            state_d = StFetchx;
          end
        end else begin
          j_d     = j_q + LH'(1);
          state_d = StHh;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      j_q     <= '0;
      t_q     <= '0;
      len_q   <= '0;
      x_q     <= '0;
      bih_q   <= '0;
      ih_q    <= '0;
      for (int k = 0; k < HIDDEN; k++) begin
        bias_q[k]  <= '0;
        hprev_q[k] <= '0;
        hnew_q[k]  <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      j_q     <= j_d;
      t_q     <= t_d;
      len_q   <= len_d;
      x_q     <= x_d;
      bih_q   <= bih_d;
      ih_q    <= ih_d;
      bias_q  <= bias_d;
      hprev_q <= hprev_d;
      hnew_q  <= hnew_d;
    end
  end

endmodule

// File: tb/tb_rnn_param.sv
`timescale 1ns/1ps
module tb_rnn_param;
  localparam int H = 4;
  localparam int N = 4;
  localparam int DW = 20;
  localparam int FRAC = 16;
  localparam int TW = 11;
  localparam int AW = 17;

  logic          clk = 1'b0;
  logic          reset;
  logic          ready;
  logic          busy;
  logic          i_en;
  logic [N-1:0]  idata;
  logic          mce;
  logic [2:0]    msel;
  logic [AW-1:0] maddr;
  logic [DW-1:0] mdata_r;
  logic [DW-1:0] mdata_w;

  always #5 clk = ~clk;

  rnn_param #(.HIDDEN(H), .IN_BITS(N), .DW(DW), .FRAC(FRAC), .TW(TW), .AW(AW)) dut (
    .clk     (clk),
    .reset   (reset),
    .ready   (ready),
    .busy    (busy),
    .i_en    (i_en),
    .idata   (idata),
    .mce     (mce),
    .msel    (msel),
    .maddr   (maddr),
    .mdata_r (mdata_r),
    .mdata_w (mdata_w)
  );

  // Parameter memory contents.
  logic [DW-1:0] wih [16];
  logic [DW-1:0] whh [16];
  logic [DW-1:0] bih [H];
  logic [DW-1:0] bhh [H];
  logic [DW-1:0] len_v;
  logic [N-1:0]  xs [$];

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            gap;
    bit            last;
  } exp_t;
  exp_t sbq [$];
  exp_t e;

  int checks = 0;
  int failures = 0;
  int ien_cnt = 0;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  // Memory: address captured mid-cycle, data returned on the next cycle.
  logic          rd_v;
  logic [2:0]    rd_sel;
  logic [AW-1:0] rd_addr;
  always @(negedge clk) begin
    rd_v = mce;
    rd_sel = msel;
    rd_addr = maddr;
  end
  always @(posedge clk) begin
    if (rd_v) begin
      case (rd_sel)
        3'd0: mdata_r <= wih[rd_addr[3:0]];
        3'd1: mdata_r <= bih[rd_addr[1:0]];
        3'd2: mdata_r <= whh[rd_addr[3:0]];
        3'd3: mdata_r <= bhh[rd_addr[1:0]];
        3'd4: mdata_r <= len_v;
        default: mdata_r <= DW'($urandom);
      endcase
    end else begin
      mdata_r <= DW'($urandom);
    end
  end

  // Input vector source: junk except in the cycle after an i_en pulse.
  bit pend = 1'b0;
  always @(negedge clk) begin
    if (i_en) begin
      ien_cnt++;
      pend = 1'b1;
      idata = N'($urandom);
    end else if (pend) begin
      idata = (xs.size() != 0) ? xs.pop_front() : '0;
      pend = 1'b0;
    end else begin
      idata = N'($urandom);
    end
  end

  // Monitor: checks each output write against the scoreboard, its cycle
  // spacing, and that busy drops right after the final write.
  int cyc = 0;
  int mark = 0;
  bit busy_d = 1'b0;
  bit chk_fall = 1'b0;
  always @(negedge clk) begin
    cyc++;
    if (chk_fall) begin
      chk_fall = 1'b0;
      chk("busy_fall", busy, 0);
    end
    if (busy && !busy_d) mark = cyc;
    busy_d = busy;
    if (mce && msel == 3'b101) begin
      if (sbq.size() == 0) begin
        chk("unexpected_write", maddr, 'h1ffff_ffff);
      end else begin
        e = sbq.pop_front();
        chk("wr_addr", maddr, e.addr);
        chk("wr_data", mdata_w, e.data);
        chk("wr_gap", cyc - mark, e.gap);
        mark = cyc;
        chk_fall = e.last;
      end
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 16; i++) begin
      wih[i] = '0;
      whh[i] = '0;
    end
    for (int j = 0; j < H; j++) begin
      bih[j] = '0;
      bhh[j] = '0;
    end
    len_v = '0;
  endtask

  task automatic set_bias(input logic [DW-1:0] bi, input logic [DW-1:0] bh);
    for (int j = 0; j < H; j++) begin
      bih[j] = bi;
      bhh[j] = bh;
    end
  endtask

  task automatic push(input int t, input int j, input int lmax, input logic [DW-1:0] d);
    exp_t x;
    x.addr = AW'(t * H + j);
    x.data = d;
    x.gap  = (t == 0 && j == 0) ? 3 * H + N + 8 : ((j == 0) ? H + N + 6 : H + N + 4);
    x.last = (t == lmax) && (j == H - 1);
    sbq.push_back(x);
  endtask

  task automatic wait_busy(input bit lvl, input int budget, input string name);
    int n = 0;
    while (busy !== lvl && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, busy, lvl);
  endtask

  task automatic run_seq(input string name, input int lmax);
    int ie0;
    ie0 = ien_cnt;
    ready = 1'b1;
    wait_busy(1'b1, 10, {name, "_start"});
    ready = 1'b0;
    wait_busy(1'b0, 3000, {name, "_done"});
    repeat (2) @(negedge clk);
    chk({name, "_drained"}, sbq.size(), 0);
    chk({name, "_ien"}, ien_cnt - ie0, lmax + 1);
    sbq.delete();
    xs.delete();
  endtask

  int ie_r;
  int rnd;

  initial begin
    reset = 1'b1;
    ready = 1'b0;
    clear_mem();
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_i_en", i_en, 0);
    chk("rst_mce", mce, 0);
    chk("rst_msel", msel, 0);
    chk("rst_maddr", maddr, 0);
    chk("rst_mdata_w", mdata_w, 0);
    reset = 1'b0;
    @(negedge clk);

    // Short sequence: bias only, 0.125 + 0.125.
    clear_mem();
    set_bias(20'h02000, 20'h02000);
    xs.push_back('0);
    for (int j = 0; j < H; j++) push(0, j, 0, 20'h04000);
    run_seq("short", 0);

    // Saturation high: 1.0 + 0.5 -> +1.0.
    clear_mem();
    set_bias(20'h10000, 20'h08000);
    xs.push_back('0);
    for (int j = 0; j < H; j++) push(0, j, 0, 20'h10000);
    run_seq("sat_hi", 0);

    // Saturation low: -1.0 + -1.0 -> -1.0.
    clear_mem();
    set_bias(20'hF0000, 20'hF0000);
    xs.push_back('0);
    for (int j = 0; j < H; j++) push(0, j, 0, 20'hF0000);
    run_seq("sat_lo", 0);

    // Recurrence: W_hh = 0.5*I, bias 0.5 -> 0.5, 0.75, 0.875.
    clear_mem();
    set_bias(20'h04000, 20'h04000);
    for (int j = 0; j < H; j++) whh[j * H + j] = 20'h08000;
    len_v = 20'd2;
    repeat (3) xs.push_back('0);
    for (int j = 0; j < H; j++) push(0, j, 2, 20'h08000);
    for (int j = 0; j < H; j++) push(1, j, 2, 20'h0C000);
    for (int j = 0; j < H; j++) push(2, j, 2, 20'h0E000);
    run_seq("recur", 2);

    // Rounding: 1 LSB * 0.5 is exactly half an LSB.
    clear_mem();
    set_bias(20'h04000, 20'h04000);
    for (int j = 0; j < H; j++) whh[j * H + j] = 20'h00001;
    len_v = 20'd1;
    repeat (2) xs.push_back('0);
`ifdef RNN_ROUND_EN
    rnd = 1;
`else
    rnd = 0;
`endif
    for (int j = 0; j < H; j++) push(0, j, 1, 20'h08000);
    for (int j = 0; j < H; j++) push(1, j, 1, DW'(32'h08000 + rnd));
    run_seq("round", 1);

    // Input bits: W_ih = 1 LSB everywhere; two and three set bits.
    clear_mem();
    set_bias(20'h02000, 20'h02000);
    for (int i = 0; i < 16; i++) wih[i] = 20'h00001;
    len_v = 20'd1;
    xs.push_back(4'b1001);
    xs.push_back(4'b0111);
    for (int j = 0; j < H; j++) push(0, j, 1, 20'h04002);
    for (int j = 0; j < H; j++) push(1, j, 1, 20'h04003);
    run_seq("xbits", 1);

    // Reset during the first HH phase: no writes, only the one i_en.
    clear_mem();
    set_bias(20'h04000, 20'h04000);
    len_v = 20'd2;
    repeat (3) xs.push_back('0);
    ie_r = ien_cnt;
    ready = 1'b1;
    wait_busy(1'b1, 10, "rst_mid_start");
    ready = 1'b0;
    repeat (14) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_mce", mce, 0);
    chk("rst_mid_msel", msel, 0);
    chk("rst_mid_maddr", maddr, 0);
    @(negedge clk);
    chk("rst_mid_i_en", i_en, 0);
    chk("rst_mid_mdata_w", mdata_w, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (60) @(negedge clk);
    chk("rst_mid_ien", ien_cnt - ie_r, 1);
    chk("rst_mid_idle", busy, 0);
    xs.delete();

    // Retrigger with ready held: second run restarts from h = 0.
    clear_mem();
    set_bias(20'h04000, 20'h04000);
    for (int j = 0; j < H; j++) whh[j * H + j] = 20'h08000;
    len_v = 20'd1;
    repeat (4) xs.push_back('0);
    for (int r = 0; r < 2; r++) begin
      for (int j = 0; j < H; j++) push(0, j, 1, 20'h08000);
      for (int j = 0; j < H; j++) push(1, j, 1, 20'h0C000);
    end
    ie_r = ien_cnt;
    ready = 1'b1;
    wait_busy(1'b1, 10, "retrig_start1");
    wait_busy(1'b0, 3000, "retrig_done1");
    wait_busy(1'b1, 3, "retrig_start2");
    ready = 1'b0;
    wait_busy(1'b0, 3000, "retrig_done2");
    repeat (2) @(negedge clk);
    chk("retrig_drained", sbq.size(), 0);
    chk("retrig_ien", ien_cnt - ie_r, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
